core_clk_reset_seq: RTL and testbench

CORE_CLK_RESET_SEQ -- requirements
Module: core_clk_reset_seq

---
 rtl/core_clk_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/core_clk_reset_seq.sv | 131 +++++++++++++
 tb/tb_core_clk_reset_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_clk_pkg.sv
// Shared sequencer state encoding and default timing constants for the core
// clock/reset sequencer.
package core_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  localparam int unsigned HOLD_CYCLES_DEF = 1024;
  localparam int unsigned LOCK_FILTER_DEF = 16;

  // A count of one still needs a 1-bit register.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/core_clk_reset_seq.sv
// Sequences the game-core reset from PLL lock and derives the 24/12/6 MHz
// clock enables from the 48 MHz system clock once the core is running.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   WAIT_LOCK | PLL not locked; core held in reset
//   FILTER    | lock seen, waiting for LOCK_FILTER consecutive lock cycles
//   HOLD      | lock stable, holding core reset for HOLD_CYCLES cycles
//   RUN       | core out of reset, clock enables running
module core_clk_reset_seq
  import core_clk_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int unsigned LOCK_FILTER = LOCK_FILTER_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  input  logic soft_reset,
  output logic core_reset,
  output logic ce_24m,
  output logic ce_12m,
  output logic ce_6m,
  output logic ready
);

  localparam int unsigned FW = cnt_width(LOCK_FILTER);
  localparam int unsigned HW = cnt_width(HOLD_CYCLES);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic lock_s;

  seq_state_e state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [2:0]    phase_q, phase_d;
  logic          run_d;

  logic core_reset_q, ready_q, ce_24m_q, ce_12m_q, ce_6m_q;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  // Loss of lock is checked first in every state so it always beats soft_reset.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = FILTER;
          fcnt_d  = '0;
        end
      end
      FILTER: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          fcnt_d  = '0;
        end else if (fcnt_q == FILT_LAST) begin
          state_d = HOLD;
          hcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          hcnt_d  = '0;
        end else if (soft_reset) begin
          hcnt_d = '0;
        end else if (hcnt_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (soft_reset) begin
          state_d = HOLD;
          hcnt_d  = '0;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    run_d   = (state_d == RUN);
    phase_d = (run_d && (state_q == RUN)) ? phase_q + 3'd1 : 3'd0;
  end

  // Enables decode the previous phase, so the first ce_24m lands two cycles
  // after core_reset falls; gating with run_d zeroes them on the exit edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_LOCK;
      fcnt_q       <= '0;
      hcnt_q       <= '0;
      phase_q      <= 3'd0;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      ce_24m_q     <= 1'b0;
      ce_12m_q     <= 1'b0;
      ce_6m_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      hcnt_q       <= hcnt_d;
      phase_q      <= phase_d;
      core_reset_q <= !run_d;
      ready_q      <= run_d;
      ce_24m_q     <= run_d && phase_q[0];
      ce_12m_q     <= run_d && (phase_q[1:0] == 2'd3);
      ce_6m_q      <= run_d && (phase_q == 3'd7);
    end
  end

  assign core_reset = core_reset_q;
  assign ready      = ready_q;
  assign ce_24m     = ce_24m_q;
  assign ce_12m     = ce_12m_q;
  assign ce_6m      = ce_6m_q;

endmodule

// File: tb/tb_core_clk_reset_seq.sv
// Directed bench for core_clk_reset_seq with HOLD_CYCLES=8, LOCK_FILTER=4.
module tb_core_clk_reset_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b0;
  logic soft_reset = 1'b0;
  logic core_reset, ce_24m, ce_12m, ce_6m, ready;

  int checks = 0;
  int failures = 0;

  always #10 clk = ~clk;

  core_clk_reset_seq #(
    .HOLD_CYCLES (8),
    .LOCK_FILTER (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .soft_reset (soft_reset),
    .core_reset (core_reset),
    .ce_24m     (ce_24m),
    .ce_12m     (ce_12m),
    .ce_6m      (ce_6m),
    .ready      (ready)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until core_reset is observed low; -1 when the budget expires.
  task automatic wait_fall(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (core_reset == 1'b0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pll_locked = 1'b0; soft_reset = 1'b0;
    repeat (5) step();
    checks++;
    if (core_reset !== 1'b1) begin failures++; $display("FAIL reset_core_reset: got %b want 1", core_reset); end
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++;
    if ({ce_24m, ce_12m, ce_6m} !== 3'b000)
      begin failures++; $display("FAIL reset_ce: got %b want 000", {ce_24m, ce_12m, ce_6m}); end
  endtask

  task automatic test_lock_sequence();
    int n;
    pll_locked = 1'b1;
    rst = 1'b0;
    wait_fall(n);
    checks++;
    if (n !== 15) begin failures++; $display("FAIL lock_seq_latency: got %0d want 15", n); end
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL lock_seq_ready: got %b want 1", ready); end
    checks++;
    if (ce_24m !== 1'b0) begin failures++; $display("FAIL lock_seq_ce24_at_fall: got %b want 0", ce_24m); end
  endtask

  task automatic test_enables();
    int c24, c12, c6, f24, f12, f6, bad_subset, ready_low;
    c24 = 0; c12 = 0; c6 = 0; f24 = 0; f12 = 0; f6 = 0; bad_subset = 0; ready_low = 0;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (ce_24m) begin c24++; if (f24 == 0) f24 = i; end
      if (ce_12m) begin c12++; if (f12 == 0) f12 = i; end
      if (ce_6m)  begin c6++;  if (f6 == 0)  f6 = i;  end
      if ((ce_6m && !(ce_12m && ce_24m)) || (ce_12m && !ce_24m)) bad_subset++;
      if (!ready || core_reset) ready_low++;
    end
    checks++;
    if (f24 !== 2) begin failures++; $display("FAIL ce24_first: got %0d want 2", f24); end
    checks++;
    if (f12 !== 4) begin failures++; $display("FAIL ce12_first: got %0d want 4", f12); end
    checks++;
    if (f6 !== 8) begin failures++; $display("FAIL ce6_first: got %0d want 8", f6); end
    checks++;
    if (c24 !== 32) begin failures++; $display("FAIL ce24_count: got %0d want 32", c24); end
    checks++;
    if (c12 !== 16) begin failures++; $display("FAIL ce12_count: got %0d want 16", c12); end
    checks++;
    if (c6 !== 8) begin failures++; $display("FAIL ce6_count: got %0d want 8", c6); end
    checks++;
    if (bad_subset !== 0) begin failures++; $display("FAIL ce_subset: got %0d violations want 0", bad_subset); end
    checks++;
    if (ready_low !== 0) begin failures++; $display("FAIL run_stable: got %0d non-run cycles want 0", ready_low); end
  endtask

  task automatic test_soft_reset();
    int n;
    repeat (3) step();
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    checks++;
    if (core_reset !== 1'b1) begin failures++; $display("FAIL soft_core_reset: got %b want 1", core_reset); end
    checks++;
    if ({ready, ce_24m, ce_12m, ce_6m} !== 4'b0000)
      begin failures++; $display("FAIL soft_outputs: got %b want 0000", {ready, ce_24m, ce_12m, ce_6m}); end
    wait_fall(n);
    checks++;
    if (n !== 8) begin failures++; $display("FAIL soft_hold_len: got %0d want 8", n); end
    step();
    checks++;
    if (ce_24m !== 1'b0) begin failures++; $display("FAIL soft_phase_c1: got %b want 0", ce_24m); end
    step();
    checks++;
    if ({ce_24m, ce_12m} !== 2'b10)
      begin failures++; $display("FAIL soft_phase_c2: got %b want 10", {ce_24m, ce_12m}); end
  endtask

  task automatic test_soft_in_hold();
    int n;
    step();
    soft_reset = 1'b1; step(); soft_reset = 1'b0;
    repeat (3) step();
    soft_reset = 1'b1; step(); soft_reset = 1'b0;
    checks++;
    if (core_reset !== 1'b1) begin failures++; $display("FAIL hold_soft_core_reset: got %b want 1", core_reset); end
    wait_fall(n);
    checks++;
    if (n !== 8) begin failures++; $display("FAIL hold_soft_restart: got %0d want 8", n); end
  endtask

  task automatic test_lock_loss();
    int n;
    repeat (5) step();
    pll_locked = 1'b0;
    repeat (3) step();
    checks++;
    if (core_reset !== 1'b1) begin failures++; $display("FAIL lock_loss_3edges: got %b want 1", core_reset); end
    checks++;
    if ({ready, ce_24m, ce_12m, ce_6m} !== 4'b0000)
      begin failures++; $display("FAIL lock_loss_outputs: got %b want 0000", {ready, ce_24m, ce_12m, ce_6m}); end
    pll_locked = 1'b1;
    wait_fall(n);
    checks++;
    if (n !== 15) begin failures++; $display("FAIL lock_loss_relock: got %0d want 15", n); end
  endtask

  task automatic test_lock_soft_simul();
    int n;
    repeat (2) step();
    pll_locked = 1'b0;
    soft_reset = 1'b1;
    step();
    checks++;
    if (core_reset !== 1'b1) begin failures++; $display("FAIL simul_core_reset: got %b want 1", core_reset); end
    repeat (3) step();
    pll_locked = 1'b1;
    repeat (4) step();
    soft_reset = 1'b0;
    wait_fall(n);
    // WAIT_LOCK path: relock sync, filter and hold end 15 edges after restore.
    checks++;
    if (n !== 11) begin failures++; $display("FAIL simul_lock_priority: got %0d want 11", n); end
  endtask

  task automatic test_glitch();
    int n;
    int early;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n = -1;
    early = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (i == 3) pll_locked = 1'b0;
      if (i == 4) pll_locked = 1'b1;
      if (ready && core_reset) early++;
      if (core_reset == 1'b0) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n !== 19) begin failures++; $display("FAIL glitch_refilter: got %0d want 19", n); end
    checks++;
    if (early !== 0) begin failures++; $display("FAIL glitch_ready_mismatch: got %0d want 0", early); end
  endtask

  task automatic test_rst_mid_hold();
    int n;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({core_reset, ready, ce_24m, ce_12m, ce_6m} !== 5'b10000)
      begin failures++; $display("FAIL rst_from_run: got %b want 10000", {core_reset, ready, ce_24m, ce_12m, ce_6m}); end
    repeat (12) step();
    checks++;
    if (core_reset !== 1'b1) begin failures++; $display("FAIL rst_mid_hold_pre: got %b want 1", core_reset); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({core_reset, ready, ce_24m, ce_12m, ce_6m} !== 5'b10000)
      begin failures++; $display("FAIL rst_mid_hold: got %b want 10000", {core_reset, ready, ce_24m, ce_12m, ce_6m}); end
    wait_fall(n);
    checks++;
    if (n !== 15) begin failures++; $display("FAIL rst_mid_hold_restart: got %0d want 15", n); end
  endtask

  initial begin
    test_reset();
    test_lock_sequence();
    test_enables();
    test_soft_reset();
    test_soft_in_hold();
    test_lock_loss();
    test_lock_soft_simul();
    test_glitch();
    test_rst_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
